bp_stall_profiler_bank: RTL and testbench
=========================================

Name: bp_stall_profiler_bank

Overview:
Parametrised stall-accounting counter bank for the BlackParrot core. It consumes one already-encoded stall reason per cycle, plus a retire flag, and accumulates per-reason cycle counts, retired-instruction count and total cycle count in a live bank. A controller FSM provides start/stop, clear and snapshot. Software-visible reads are served from a shadow bank with 1-cycle latency. Successor to the fixed 24-reason profiler: reason count, counter width and saturate/wrap mode are configurable; snapshot, clear, sticky overflow and read port are new.

Parameters:
num_reasons_p, 24, number of stall-reason counters; reason 0 = unknown
ctr_width_p, 32, width of every counter (2..64)
saturate_p, 1, 1 = counters saturate at all-ones; 0 = counters wrap
addr_width_lp, $clog2(num_reasons_p+2), read address width (derived)
reason_width_lp, $clog2(num_reasons_p), stall reason index width (derived)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
freeze_i  in  1  core frozen; suppresses all counting
en_i  in  1  level; 1 = counting enabled
clear_i  in  1  pulse; zero live bank and overflow flags
snapshot_i  in  1  pulse; copy live bank to shadow bank
instret_i  in  1  instruction retired this cycle
stall_v_i  in  1  stall_reason_i valid
stall_reason_i  in  reason_width_lp  encoded stall reason
rd_v_i  in  1  read request
rd_addr_i  in  addr_width_lp  0..N-1 = reason ctr, N = instret, N+1 = cycles
rd_v_o  out  1  read data valid
rd_data_o  out  ctr_width_p  read data
busy_o  out  1  high while in e_clear
overflow_o  out  num_reasons_p+2  sticky per-counter overflow, same index map as reads

Behaviour:
- Reset (async assert on reset_n_i=0, synchronous deassert by the system): both banks 0, overflow_o 0, rd_v_o 0, rd_data_o 0, state e_idle.
- FSM states:
  - e_idle: no counting. en_i=1 -> e_run.
  - e_run: counting. en_i=0 -> e_idle.
  - e_clear: one cycle. Zero live bank and overflow_o. Next state is e_run if en_i=1, else e_idle.
- clear_i in any state -> e_clear next cycle. The cycle in which clear_i is sampled still counts normally if in e_run.
- Priority in a cycle: clear_i > snapshot_i > en_i transition.
- clear_i and snapshot_i together: clear taken, snapshot dropped.
- Counting condition: state == e_run and ~freeze_i. When true, per cycle:
  - cycle counter (index N+1) increments.
  - If instret_i: instret counter (index N) increments; stall inputs ignored.
  - Else if stall_v_i and stall_reason_i < num_reasons_p: counter[stall_reason_i] increments.
  - Else: counter[0] (unknown) increments.
- Exactly one of {instret, one reason counter} increments per counted cycle.
- Invariant (no overflow): cycles == instret + sum(reason counters).
- Overflow, for an increment at all-ones:
  - saturate_p=1: value holds.
  - saturate_p=0: value wraps to 0.
  - Either mode: overflow_o bit set and held until e_clear or reset.
- snapshot_i, when taken: shadow <= live next-state value, so the current cycle's increment is included. Legal in any state except e_clear, where it is ignored.
- Read port:
  - rd_v_i sampled -> rd_v_o=1 and rd_data_o=shadow[rd_addr_i] the next cycle.
  - One read per cycle; back-to-back reads supported; no backpressure.
  - rd_addr_i > N+1 returns 0 with rd_v_o=1.
  - Reads are never affected by the live bank or e_clear.
  - rd_data_o holds its last value when rd_v_o=0.
- busy_o = (state == e_clear).

Decomposition:
- Shared package bp_profiler_pkg:
  - bp_profiler_state_e {e_idle, e_run, e_clear}
  - address offset constants for instret (N) and cycles (N+1)
  - the existing bp_stall_reason_e, retained as the default reason encoding
- Sub-module bp_profiler_ctr: one ctr_width_p counter with clear, increment, saturate_p mode and sticky overflow; instantiated num_reasons_p+2 times.
- The shadow bank is a flopped array in the top level.

Test Plan:
- Reset, en_i=1, 10 cycles with instret_i=1, snapshot, read addr N and N+1 -> 10 and 10; all reason counters read 0.
- In e_run, reason 5 for 3 cycles, then reason 30 for 2 cycles (N=24), then stall_v_i=0 for 1 cycle, snapshot -> ctr[5]=3, ctr[0]=3, cycles=6.
- freeze_i=1 for 4 cycles with reason 7 valid, then en_i=0 for 4 more, snapshot -> ctr[7]=0 and cycles unchanged.
- ctr_width_p=4: 20 cycles of reason 2.
  - saturate_p=1 -> ctr[2]=15, overflow_o[2]=1.
  - saturate_p=0 -> ctr[2]=4, overflow_o[2]=1.
- clear_i and snapshot_i in the same cycle, after 8 counted cycles -> shadow unchanged (prior values), busy_o=1 for one cycle; next snapshot -> all 0 plus cycles counted since.
- Assert reset_n_i mid-run, between rd_v_i and rd_v_o -> rd_v_o=0, all reads after release return 0, state e_idle.

Source files
------------

// File: rtl/bp_profiler_pkg.sv
// Shared types and constants for the stall-accounting profiler bank.
// Contents:
//   bp_profiler_state_e : controller state (idle / run / clear)
//   instret_offset, cycles_offset, instret_addr(), cycles_addr() :
//      location of the two fixed counters after the N reason counters
//   bp_stall_reason_e   : default stall-reason encoding (reason 0 = unknown)
package bp_profiler_pkg;

   typedef enum logic [1:0] {
      e_idle  = 2'd0,
      e_run   = 2'd1,
      e_clear = 2'd2
   } bp_profiler_state_e;

   // The two fixed counters sit directly above the N reason counters.
   localparam int unsigned instret_offset = 0;
   localparam int unsigned cycles_offset  = 1;

   function automatic int unsigned instret_addr(input int unsigned num_reasons);
      return num_reasons + instret_offset;
   endfunction

   function automatic int unsigned cycles_addr(input int unsigned num_reasons);
      return num_reasons + cycles_offset;
   endfunction

   // Default reason encoding carried over from the fixed 24-reason profiler.
   typedef enum logic [4:0] {
      e_reason_unknown         = 5'd0,
      e_reason_ic_miss         = 5'd1,
      e_reason_br_ovr          = 5'd2,
      e_reason_ret_ovr         = 5'd3,
      e_reason_icache_fence    = 5'd4,
      e_reason_fe_cmd          = 5'd5,
      e_reason_fe_cmd_fence    = 5'd6,
      e_reason_mispredict      = 5'd7,
      e_reason_control_haz     = 5'd8,
      e_reason_long_haz        = 5'd9,
      e_reason_data_haz        = 5'd10,
      e_reason_aux_dep         = 5'd11,
      e_reason_load_dep        = 5'd12,
      e_reason_mul_dep         = 5'd13,
      e_reason_fma_dep         = 5'd14,
      e_reason_sb_iraw_dep     = 5'd15,
      e_reason_sb_fraw_dep     = 5'd16,
      e_reason_sb_iwaw_dep     = 5'd17,
      e_reason_sb_fwaw_dep     = 5'd18,
      e_reason_struct_haz      = 5'd19,
      e_reason_dcache_miss     = 5'd20,
      e_reason_dcache_rollback = 5'd21,
      e_reason_exception       = 5'd22,
      e_reason_cmd_fence       = 5'd23
   } bp_stall_reason_e;

endpackage

// File: rtl/bp_stall_profiler_bank_if.sv
// Software read port of the profiler bank.
// Signals:
//   rd_v      request valid (one per cycle, no backpressure)
//   rd_addr   0..N-1 reason counters, N instret, N+1 cycles
//   rd_data_v read data valid, one cycle after rd_v
//   rd_data   read data, holds when rd_data_v is low
interface bp_stall_profiler_bank_if #(
   parameter int unsigned addr_width_p = 5,
   parameter int unsigned data_width_p = 32
) ();

   logic                    rd_v;
   logic [addr_width_p-1:0] rd_addr;
   logic                    rd_data_v;
   logic [data_width_p-1:0] rd_data;

   modport master (output rd_v, output rd_addr, input rd_data_v, input rd_data);
   modport slave  (input rd_v, input rd_addr, output rd_data_v, output rd_data);

endinterface

// File: rtl/bp_profiler_ctr.sv
// Single profiler counter: synchronous clear, increment, saturate-or-wrap
// at all-ones, and a sticky overflow flag.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          zero the count and the overflow flag (wins over inc)
//   inc          increment this cycle
//   count_next_c value the count takes at the next edge (for snapshots)
//   overflow     sticky, set by any increment attempted at all-ones
module bp_profiler_ctr #(
   parameter int unsigned width_p    = 32,
   parameter int unsigned saturate_p = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               inc,
   output logic [width_p-1:0] count_next_c,
   output logic               overflow
);

   logic [width_p-1:0] count_q;
   logic               overflow_next;

   // Next count and overflow flag.
   always_comb begin
      count_next_c  = count_q;
      overflow_next = overflow;
      if (clr) begin
         count_next_c  = '0;
         overflow_next = 1'b0;
      end else if (inc) begin
         if (&count_q) begin
            overflow_next = 1'b1;
            count_next_c  = (saturate_p != 0) ? count_q : '0;
         end else begin
            count_next_c = count_q + width_p'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         count_q  <= count_next_c;
         overflow <= overflow_next;
      end
   end

endmodule

// File: rtl/bp_stall_profiler_bank.sv
// Stall-accounting counter bank: per-reason stall cycles, retired
// instructions and total cycles in a live bank, copied on snapshot into a
// shadow bank that serves software reads with one cycle of latency.
// Ports:
//   clk_i, reset_n_i   clock, async active-low reset
//   freeze_i           core frozen, nothing counts
//   en_i               counting enable (level)
//   clear_i            zero live bank and overflow flags (pulse)
//   snapshot_i         copy live bank to shadow bank (pulse)
//   instret_i          instruction retired this cycle
//   stall_v_i          stall_reason_i valid
//   stall_reason_i     encoded stall reason
//   rd                 read port (slave side)
//   busy_o             high while the bank is being cleared
//   overflow_o         sticky per-counter overflow, read-address index map
module bp_stall_profiler_bank
   import bp_profiler_pkg::*;
#(
   parameter  int unsigned num_reasons_p   = 24,
   parameter  int unsigned ctr_width_p     = 32,
   parameter  int unsigned saturate_p      = 1,
   localparam int unsigned addr_width_lp   = $clog2(num_reasons_p + 2),
   localparam int unsigned reason_width_lp = $clog2(num_reasons_p)
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       freeze_i,
   input  logic                       en_i,
   input  logic                       clear_i,
   input  logic                       snapshot_i,
   input  logic                       instret_i,
   input  logic                       stall_v_i,
   input  logic [reason_width_lp-1:0] stall_reason_i,
   bp_stall_profiler_bank_if.slave    rd,
   output logic                       busy_o,
   output logic [num_reasons_p+1:0]   overflow_o
);

   localparam int unsigned num_ctrs_lp    = num_reasons_p + 2;
   localparam int unsigned instret_idx_lp = instret_addr(num_reasons_p);
   localparam int unsigned cycles_idx_lp  = cycles_addr(num_reasons_p);
   localparam int unsigned shadow_depth_lp = 1 << addr_width_lp;

   bp_profiler_state_e state_q, state_next;

   logic                     count_en_c;
   logic                     snap_take_c;
   logic                     clr_c;
   logic [num_ctrs_lp-1:0]   inc_c;
   logic [ctr_width_p-1:0]   live_next [num_ctrs_lp];
   logic [ctr_width_p-1:0]   shadow_q  [shadow_depth_lp];

   // Controller next state; clear_i wins from any state.
   always_comb begin
      state_next = state_q;
      if (clear_i) begin
         state_next = e_clear;
      end else begin
         case (state_q)
            e_idle:  if (en_i)  state_next = e_run;
            e_run:   if (!en_i) state_next = e_idle;
            e_clear: state_next = en_i ? e_run : e_idle;
            default: state_next = e_idle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= e_idle;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_next;
         busy_o  <= (state_next == e_clear);
      end
   end

   assign count_en_c  = (state_q == e_run) && !freeze_i;
   assign clr_c       = (state_q == e_clear);
   assign snap_take_c = snapshot_i && !clear_i && (state_q != e_clear);

   // One-hot increment: cycles always, plus exactly one of instret or a reason.
   always_comb begin
      inc_c = '0;
      if (count_en_c) begin
         inc_c[cycles_idx_lp] = 1'b1;
         if (instret_i) begin
            inc_c[instret_idx_lp] = 1'b1;
         end else if (stall_v_i && (32'(stall_reason_i) < num_reasons_p)) begin
            inc_c[addr_width_lp'(stall_reason_i)] = 1'b1;
         end else begin
            inc_c[0] = 1'b1;
         end
      end
   end

   for (genvar i = 0; i < num_ctrs_lp; i++) begin : g_ctr
      bp_profiler_ctr #(
         .width_p    (ctr_width_p),
         .saturate_p (saturate_p)
      ) u_ctr (
         .clk          (clk_i),
         .rst_n        (reset_n_i),
         .clr          (clr_c),
         .inc          (inc_c[i]),
         .count_next_c (live_next[i]),
         .overflow     (overflow_o[i])
      );
   end

   // Shadow bank padded to the full address space; the unused upper
   // entries stay zero so out-of-range reads return 0 without a compare.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < shadow_depth_lp; i++) shadow_q[i] <= '0;
      end else if (snap_take_c) begin
         for (int i = 0; i < num_ctrs_lp; i++) shadow_q[i] <= live_next[i];
      end
   end

   // Read port: one-cycle latency, data holds between reads.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd.rd_data_v <= 1'b0;
         rd.rd_data   <= '0;
      end else begin
         rd.rd_data_v <= rd.rd_v;
         if (rd.rd_v) rd.rd_data <= shadow_q[rd.rd_addr];
      end
   end

endmodule

// File: tb/tb_bp_stall_profiler_bank.sv
// Bench for bp_stall_profiler_bank: a 32-bit saturating bank and two 4-bit
// banks (saturating and wrapping) share one stimulus stream and are compared
// every cycle against a per-bank reference model.
module tb_bp_stall_profiler_bank;

   localparam int unsigned N  = 24;
   localparam int unsigned NC = N + 2;
   localparam int unsigned AW = 5;
   localparam int unsigned RW = 5;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_CLEAR = 2;

   logic clk;
   logic reset_n, freeze, en, clear, snapshot, instret, stall_v;
   logic [RW-1:0] stall_reason;
   logic rd_v;
   logic [AW-1:0] rd_addr;
   logic busy_main, busy_sat, busy_wrap;
   logic [NC-1:0] ovf_main, ovf_sat, ovf_wrap;

   bp_stall_profiler_bank_if #(.addr_width_p(AW), .data_width_p(32)) if_main ();
   bp_stall_profiler_bank_if #(.addr_width_p(AW), .data_width_p(4))  if_sat ();
   bp_stall_profiler_bank_if #(.addr_width_p(AW), .data_width_p(4))  if_wrap ();

   assign if_main.rd_v    = rd_v;
   assign if_main.rd_addr = rd_addr;
   assign if_sat.rd_v     = rd_v;
   assign if_sat.rd_addr  = rd_addr;
   assign if_wrap.rd_v    = rd_v;
   assign if_wrap.rd_addr = rd_addr;

   bp_stall_profiler_bank #(.num_reasons_p(N), .ctr_width_p(32), .saturate_p(1)) u_main (
      .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .en_i(en), .clear_i(clear),
      .snapshot_i(snapshot), .instret_i(instret), .stall_v_i(stall_v),
      .stall_reason_i(stall_reason), .rd(if_main), .busy_o(busy_main), .overflow_o(ovf_main));

   bp_stall_profiler_bank #(.num_reasons_p(N), .ctr_width_p(4), .saturate_p(1)) u_sat (
      .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .en_i(en), .clear_i(clear),
      .snapshot_i(snapshot), .instret_i(instret), .stall_v_i(stall_v),
      .stall_reason_i(stall_reason), .rd(if_sat), .busy_o(busy_sat), .overflow_o(ovf_sat));

   bp_stall_profiler_bank #(.num_reasons_p(N), .ctr_width_p(4), .saturate_p(0)) u_wrap (
      .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .en_i(en), .clear_i(clear),
      .snapshot_i(snapshot), .instret_i(instret), .stall_v_i(stall_v),
      .stall_reason_i(stall_reason), .rd(if_wrap), .busy_o(busy_wrap), .overflow_o(ovf_wrap));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, one row per bank.
   int unsigned     wid [3] = '{32, 4, 4};
   bit              sat [3] = '{1'b1, 1'b1, 1'b0};
   longint unsigned m_live   [3][NC];
   longint unsigned m_shadow [3][NC];
   bit              m_ovf    [3][NC];
   longint unsigned m_rd_data [3];
   bit              m_rd_v;
   int              m_state;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned mask_of(input int unsigned w);
      return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NC; i++) begin
            m_live[k][i] = 0; m_shadow[k][i] = 0; m_ovf[k][i] = 1'b0;
         end
         m_rd_data[k] = 0;
      end
      m_rd_v  = 1'b0;
      m_state = M_IDLE;
   endtask

   task automatic bump(input int k, input int idx);
      if (m_live[k][idx] == mask_of(wid[k])) begin
         m_ovf[k][idx] = 1'b1;
         if (!sat[k]) m_live[k][idx] = 0;
      end else begin
         m_live[k][idx] = m_live[k][idx] + 1;
      end
   endtask

   // One clock edge of the specified behaviour, using the inputs held before it.
   task automatic model_cycle();
      if (!reset_n) begin
         model_reset();
         return;
      end
      m_rd_v = rd_v;
      if (rd_v)
         for (int k = 0; k < 3; k++)
            m_rd_data[k] = (int'(rd_addr) < NC) ? m_shadow[k][rd_addr] : 0;
      for (int k = 0; k < 3; k++) begin
         if (m_state == M_CLEAR) begin
            for (int i = 0; i < NC; i++) begin m_live[k][i] = 0; m_ovf[k][i] = 1'b0; end
         end else if (m_state == M_RUN && !freeze) begin
            bump(k, N + 1);
            if (instret)                             bump(k, N);
            else if (stall_v && int'(stall_reason) < N) bump(k, int'(stall_reason));
            else                                     bump(k, 0);
         end
         if (snapshot && !clear && m_state != M_CLEAR)
            for (int i = 0; i < NC; i++) m_shadow[k][i] = m_live[k][i];
      end
      if (clear)                  m_state = M_CLEAR;
      else if (m_state == M_IDLE) m_state = en ? M_RUN : M_IDLE;
      else if (m_state == M_RUN)  m_state = en ? M_RUN : M_IDLE;
      else                        m_state = en ? M_RUN : M_IDLE;
   endtask

   function automatic logic [NC-1:0] exp_ovf(input int k);
      logic [NC-1:0] v;
      v = '0;
      for (int i = 0; i < NC; i++) v[i] = m_ovf[k][i];
      return v;
   endfunction

   task automatic check_all();
      logic [63:0] eb;
      eb = 64'(m_state == M_CLEAR);
      chk("rd_v_main",  64'(if_main.rd_data_v), 64'(m_rd_v));
      chk("rd_v_sat",   64'(if_sat.rd_data_v),  64'(m_rd_v));
      chk("rd_v_wrap",  64'(if_wrap.rd_data_v), 64'(m_rd_v));
      chk("rd_data_main", 64'(if_main.rd_data), m_rd_data[0]);
      chk("rd_data_sat",  64'(if_sat.rd_data),  m_rd_data[1]);
      chk("rd_data_wrap", 64'(if_wrap.rd_data), m_rd_data[2]);
      chk("busy_main", 64'(busy_main), eb);
      chk("busy_sat",  64'(busy_sat),  eb);
      chk("busy_wrap", 64'(busy_wrap), eb);
      chk("ovf_main", 64'(ovf_main), 64'(exp_ovf(0)));
      chk("ovf_sat",  64'(ovf_sat),  64'(exp_ovf(1)));
      chk("ovf_wrap", 64'(ovf_wrap), 64'(exp_ovf(2)));
   endtask

   task automatic step();
      @(posedge clk);
      model_cycle();
      #1;
      check_all();
   endtask

   task automatic rd_at(input int a);
      rd_v = 1'b1;
      rd_addr = AW'(a);
      step();
      rd_v = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; freeze = 1'b0; en = 1'b0; clear = 1'b0; snapshot = 1'b0;
      instret = 1'b0; stall_v = 1'b0; stall_reason = '0; rd_v = 1'b0; rd_addr = '0;
      model_reset();
      #1;
      check_all();
      step(); step();
      reset_n = 1'b1;
      step();

      // Retired instructions only.
      en = 1'b1; step();
      instret = 1'b1;
      repeat (9) step();
      snapshot = 1'b1; step();
      snapshot = 1'b0; instret = 1'b0; en = 1'b0;
      rd_at(N);     chk("instret_10", 64'(if_main.rd_data), 64'd10);
      rd_at(N + 1); chk("cycles_10",  64'(if_main.rd_data), 64'd10);
      for (int a = 0; a < N; a++) begin
         rd_at(a); chk("reason_zero", 64'(if_main.rd_data), 64'd0);
      end

      // Valid, out-of-range and absent stall reasons.
      clear = 1'b1; step();
      clear = 1'b0; en = 1'b1; step();
      stall_v = 1'b1; stall_reason = RW'(5);
      repeat (3) step();
      stall_reason = RW'(30);
      repeat (2) step();
      stall_v = 1'b0; snapshot = 1'b1; step();
      snapshot = 1'b0;

      // Freeze, then disable: nothing may count.
      freeze = 1'b1; stall_v = 1'b1; stall_reason = RW'(7);
      repeat (4) step();
      en = 1'b0; step();
      freeze = 1'b0;
      repeat (3) step();
      snapshot = 1'b1; step();
      snapshot = 1'b0; stall_v = 1'b0;
      rd_at(5);     chk("reason5_3",  64'(if_main.rd_data), 64'd3);
      rd_at(0);     chk("unknown_3",  64'(if_main.rd_data), 64'd3);
      rd_at(7);     chk("reason7_0",  64'(if_main.rd_data), 64'd0);
      rd_at(N + 1); chk("cycles_6",   64'(if_main.rd_data), 64'd6);
      rd_at(31);    chk("oor_addr_0", 64'(if_main.rd_data), 64'd0);

      // Narrow counters: saturate vs wrap.
      clear = 1'b1; en = 1'b1; stall_v = 1'b1; stall_reason = RW'(2); step();
      clear = 1'b0; step();
      repeat (20) step();
      freeze = 1'b1; en = 1'b0; snapshot = 1'b1; step();
      snapshot = 1'b0; freeze = 1'b0; stall_v = 1'b0;
      rd_at(2);
      chk("r2_main_20", 64'(if_main.rd_data), 64'd20);
      chk("r2_sat_15",  64'(if_sat.rd_data),  64'd15);
      chk("r2_wrap_4",  64'(if_wrap.rd_data), 64'd4);
      chk("ovf2_sat",   64'(ovf_sat[2]),  64'd1);
      chk("ovf2_wrap",  64'(ovf_wrap[2]), 64'd1);
      chk("ovf2_main",  64'(ovf_main[2]), 64'd0);

      // Clear and snapshot together: snapshot dropped.
      clear = 1'b1; en = 1'b1; step();
      clear = 1'b0; step();
      repeat (8) step();
      clear = 1'b1; snapshot = 1'b1; step();
      clear = 1'b0; snapshot = 1'b0;
      chk("busy_hi", 64'(busy_main), 64'd1);
      step();
      chk("busy_lo", 64'(busy_main), 64'd0);
      rd_at(2); chk("shadow_kept", 64'(if_main.rd_data), 64'd20);
      snapshot = 1'b1; step();
      snapshot = 1'b0;
      rd_at(N + 1); chk("cycles_after_clr", 64'(if_main.rd_data), 64'd2);
      rd_at(2);     chk("r2_after_clr",     64'(if_main.rd_data), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         en       = ($urandom_range(0, 9) != 0);
         freeze   = ($urandom_range(0, 9) == 0);
         clear    = ($urandom_range(0, 39) == 0);
         snapshot = ($urandom_range(0, 7) == 0);
         instret  = ($urandom_range(0, 2) == 0);
         stall_v  = ($urandom_range(0, 3) != 0);
         stall_reason = RW'($urandom_range(0, 31));
         rd_v     = 1'($urandom_range(0, 1));
         rd_addr  = AW'($urandom_range(0, 31));
         step();
      end
      clear = 1'b0; freeze = 1'b0; instret = 1'b0; stall_v = 1'b0; rd_v = 1'b0;
      snapshot = 1'b1; step();
      snapshot = 1'b0;
      for (int a = 0; a < 32; a++) rd_at(a);

      // Reset between a read request and its response.
      en = 1'b1; step(); step();
      rd_v = 1'b1; rd_addr = AW'(N + 1);
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_rd_v", 64'(if_main.rd_data_v), 64'd0);
      check_all();
      rd_v = 1'b0;
      step(); step();
      reset_n = 1'b1; en = 1'b1; snapshot = 1'b1; step();
      snapshot = 1'b0;
      rd_at(N + 1); chk("rst_idle_cycles", 64'(if_main.rd_data), 64'd0);
      for (int a = 0; a < 32; a++) begin
         rd_at(a); chk("rst_read_zero", 64'(if_main.rd_data), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
